// File: rtl/hilo_pkg.sv
// hilo_pkg: shared width, FSM states and SPECIAL func codes for the HI/LO divide unit.
package hilo_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_e;

    localparam logic [5:0] DIV  = 6'b011010;
    localparam logic [5:0] DIVU = 6'b011011;
    localparam logic [5:0] MFHI = 6'b010000;
    localparam logic [5:0] MFLO = 6'b010010;
    localparam logic [5:0] MTHI = 6'b010001;
    localparam logic [5:0] MTLO = 6'b010011;

endpackage

// File: rtl/div_restoring_step.sv
// div_restoring_step: one radix-2 restoring division step (shift in a dividend bit, trial subtract).
module div_restoring_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             bit_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH:0]   diff;

    assign shifted = {rem_i, bit_i};
    assign diff    = shifted[WIDTH:0] - {1'b0, divisor_i};
    assign q_o     = shifted >= {2'b00, divisor_i};
    assign rem_o   = q_o ? diff : shifted[WIDTH:0];

endmodule

// File: rtl/hilo_divider.sv
// hilo_divider: multi-cycle restoring DIV/DIVU unit owning the HI/LO registers (MTHI/MTLO while idle).
// Define DIV_ZERO_FAST_EN to retire zero-divisor requests two edges after accept.
module hilo_divider
    import hilo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    input  logic             req_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             req_ready,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d, rem_step;
    logic [WIDTH-1:0] quo_q, quo_d, dvs_q, dvs_d, hi_q, hi_d, lo_q, lo_d;
    logic             qsign_q, qsign_d, rsign_q, rsign_d, zero_q, zero_d;
    logic             done_q, done_d, dz_q, dz_d;
    logic             q_bit, a_neg, b_neg, zero_req;
    logic [WIDTH-1:0] a_mag, b_mag;

    div_restoring_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .divisor_i (dvs_q),
        .bit_i     (quo_q[WIDTH-1]),
        .rem_o     (rem_step),
        .q_o       (q_bit)
    );

    assign a_neg    = req_signed & dividend[WIDTH-1];
    assign b_neg    = req_signed & divisor[WIDTH-1];
    assign a_mag    = a_neg ? -dividend : dividend;
    assign b_mag    = b_neg ? -divisor : divisor;
    assign zero_req = divisor == '0;

    assign req_ready = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign done      = done_q;
    assign div_zero  = dz_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        zero_d  = zero_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (hi_we) hi_d = wr_data;
                if (lo_we) lo_d = wr_data;
                if (req_valid) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = a_mag;
                    dvs_d   = b_mag;
                    qsign_d = a_neg ^ b_neg;
                    rsign_d = a_neg;
                    zero_d  = zero_req;
`ifdef DIV_ZERO_FAST_EN
                    // Preload |a| as the remainder and jump to the final RUN cycle.
                    if (zero_req) begin
                        cnt_d = CW'(WIDTH - 1);
                        rem_d = {1'b0, a_mag};
                    end
`endif
                end
            end
            RUN: begin
                rem_d = rem_step;
                quo_d = {quo_q[WIDTH-2:0], q_bit};
                cnt_d = cnt_q + 1'b1;
`ifdef DIV_ZERO_FAST_EN
                if (zero_q) begin
                    rem_d = rem_q;
                    quo_d = quo_q;
                end
`endif
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                // A zero divisor leaves |a| in the remainder, so the sign fix restores the raw dividend.
                lo_d    = zero_q ? '1 : (qsign_q ? -quo_q : quo_q);
                hi_d    = rsign_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                dz_d    = zero_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            zero_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            zero_q  <= zero_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

endmodule
